// File: rtl/byte_serial_adder_ctrl.sv
// Wide adder built from one 8-bit add slice reused once per clock, LSB byte first.
// Start/busy/done handshake; result and carry-out are held until the next completion.
module byte_serial_adder_ctrl #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8*NUM_BYTES-1:0]   A,
  input  logic [8*NUM_BYTES-1:0]   B,
  input  logic                     Cin,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_BYTES-1:0]   Sum,
  output logic                     Carry
);

  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;
  logic             r_carry,     w_carry_nxt;
  logic [W-1:0]     r_part,      w_part_nxt;
  logic [W-1:0]     r_a,         w_a_nxt;
  logic [W-1:0]     r_b,         w_b_nxt;
  logic [W-1:0]     r_sum,       w_sum_nxt;
  logic             r_carry_out, w_carry_out_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_done,      w_done_nxt;

  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic [8:0]       w_add;
  logic [W-1:0]     w_part_merged;

  // Operand byte select for the current pass and the shared 8-bit add slice.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_byte = r_a[8*i +: 8];
        w_b_byte = r_b[8*i +: 8];
      end
    end
    w_add = {1'b0, w_a_byte} + {1'b0, w_b_byte} + 9'(r_carry);
  end

  // Partial sum with this pass's byte already folded in, so the final pass is included.
  always_comb begin
    w_part_merged = r_part;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_part_merged[8*i +: 8] = w_add[7:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_carry_nxt     = r_carry;
    w_part_nxt      = r_part;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_sum_nxt       = r_sum;
    w_carry_out_nxt = r_carry_out;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = A;
          w_b_nxt     = B;
          w_carry_nxt = Cin;
          w_idx_nxt   = '0;
          w_part_nxt  = '0;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        w_part_nxt  = w_part_merged;
        w_carry_nxt = w_add[8];
        if (r_idx == LAST_IDX) begin
          w_idx_nxt       = '0;
          w_sum_nxt       = w_part_merged;
          w_carry_out_nxt = w_add[8];
          w_state_nxt     = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_part      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_carry     <= w_carry_nxt;
      r_part      <= w_part_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_carry_out <= w_carry_out_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign Sum   = r_sum;
  assign Carry = r_carry_out;

endmodule
